// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decode controller. It generates the PC,
// issues instruction-memory reads (1-cycle read latency), buffers returned
// words in a 2-entry prefetch FIFO and presents one registered instruction
// together with its pre-split decode fields. Downstream stall holds the
// instruction register; a redirect flushes everything and refetches from
// redirect_pc.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-low reset
//   im_read        out  registered memory read strobe
//   im_addr        out  registered memory word address
//   im_rdata       in   memory data, valid in the cycle im_read is high
//   stall          in   downstream hold of the instruction register
//   redirect       in   taken branch/jump: flush and refetch
//   redirect_pc    in   target byte address, sampled when redirect=1
//   instr          out  registered current instruction
//   instr_pc       out  byte PC of instr
//   instr_pc_next  out  instr_pc + 4 (link value)
//   instr_valid    out  instr holds a real instruction
//   opcode         out  instr[30:25]
//   sub_op_base    out  instr[4:0]
//   sub_op_ls      out  instr[7:0]
//   sub_op_j       out  instr[24]
//   sub_op_jr      out  instr[4:0]
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned IM_ADDR_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     im_read,
  output logic [IM_ADDR_WIDTH-1:0] im_addr,
  input  logic [31:0]              im_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_pc_next,
  output logic                     instr_valid,
  output logic [5:0]               opcode,
  output logic [4:0]               sub_op_base,
  output logic [7:0]               sub_op_ls,
  output logic                     sub_op_j,
  output logic [4:0]               sub_op_jr
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic                     im_read_q, im_read_d;
  logic [IM_ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [31:0]              inflight_pc_q, inflight_pc_d;
  logic [31:0]              fifo0_data_q, fifo0_data_d;
  logic [31:0]              fifo0_pc_q, fifo0_pc_d;
  logic [31:0]              fifo1_data_q, fifo1_data_d;
  logic [31:0]              fifo1_pc_q, fifo1_pc_d;
  logic [1:0]               fifo_cnt_q, fifo_cnt_d;
  logic [31:0]              instr_q, instr_d;
  logic [31:0]              instr_pc_q, instr_pc_d;
  logic [31:0]              instr_pc_next_q, instr_pc_next_d;
  logic                     instr_valid_q, instr_valid_d;

  logic                     load_en_s;
  logic                     fifo_pop_s;
  logic                     bypass_s;
  logic                     push_s;
  logic                     pop_s;
  logic [2:0]               occ_s;
  logic                     issue_s;

  // A read issued last edge (im_read_q) returns its data this cycle, so
  // im_read_q doubles as the in-flight flag and inflight_pc_q is its PC.
  assign load_en_s  = ~stall | ~instr_valid_q;
  assign fifo_pop_s = load_en_s & (fifo_cnt_q != 2'd0);
  assign bypass_s   = load_en_s & (fifo_cnt_q == 2'd0) & im_read_q;
  assign push_s     = im_read_q & ~bypass_s;
  assign pop_s      = fifo_pop_s | bypass_s;
  // Words owned after this edge: buffered + arriving - consumed. Keeping this
  // below 2 before issuing guarantees the FIFO can always absorb the response.
  assign occ_s      = {1'b0, fifo_cnt_q} + {2'b00, im_read_q} - {2'b00, pop_s};
  assign issue_s    = (occ_s < 3'd2);

  // Next-state logic: FSM, instruction register, prefetch FIFO and requests.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    im_read_d       = im_read_q;
    im_addr_d       = im_addr_q;
    inflight_pc_d   = inflight_pc_q;
    fifo0_data_d    = fifo0_data_q;
    fifo0_pc_d      = fifo0_pc_q;
    fifo1_data_d    = fifo1_data_q;
    fifo1_pc_d      = fifo1_pc_q;
    fifo_cnt_d      = fifo_cnt_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    instr_pc_next_d = instr_pc_next_q;
    instr_valid_d   = instr_valid_q;

    case (state_q)
      S_RESET: state_d = redirect ? S_REDIR : S_RUN;
      S_RUN:   state_d = redirect ? S_REDIR : S_RUN;
      S_REDIR: state_d = redirect ? S_REDIR : S_RUN;
      default: state_d = S_RESET;
    endcase

    if (redirect) begin
      // Flush: the response arriving this edge is simply not captured, and
      // the target is requested immediately (overrides stall).
      fifo_cnt_d    = 2'd0;
      instr_valid_d = 1'b0;
      im_read_d     = 1'b1;
      im_addr_d     = redirect_pc[IM_ADDR_WIDTH+1:2];
      inflight_pc_d = redirect_pc;
      fetch_pc_d    = redirect_pc + 32'd4;
    end else begin
      if (load_en_s) begin
        if (fifo_cnt_q != 2'd0) begin
          instr_d         = fifo0_data_q;
          instr_pc_d      = fifo0_pc_q;
          instr_pc_next_d = fifo0_pc_q + 32'd4;
          instr_valid_d   = 1'b1;
        end else if (im_read_q) begin
          instr_d         = im_rdata;
          instr_pc_d      = inflight_pc_q;
          instr_pc_next_d = inflight_pc_q + 32'd4;
          instr_valid_d   = 1'b1;
        end else begin
          instr_valid_d   = 1'b0;
        end
      end else begin
        instr_valid_d = instr_valid_q;
      end

      case ({push_s, fifo_pop_s})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            fifo0_data_d = im_rdata;
            fifo0_pc_d   = inflight_pc_q;
          end else begin
            fifo1_data_d = im_rdata;
            fifo1_pc_d   = inflight_pc_q;
          end
          fifo_cnt_d = fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo0_data_d = fifo1_data_q;
          fifo0_pc_d   = fifo1_pc_q;
          fifo_cnt_d   = fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo0_data_d = im_rdata;
            fifo0_pc_d   = inflight_pc_q;
          end else begin
            fifo0_data_d = fifo1_data_q;
            fifo0_pc_d   = fifo1_pc_q;
            fifo1_data_d = im_rdata;
            fifo1_pc_d   = inflight_pc_q;
          end
        end
        default: fifo_cnt_d = fifo_cnt_q;
      endcase

      if (issue_s) begin
        im_read_d     = 1'b1;
        im_addr_d     = fetch_pc_q[IM_ADDR_WIDTH+1:2];
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end else begin
        im_read_d     = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_RESET;
      fetch_pc_q      <= PC_RESET;
      im_read_q       <= 1'b0;
      im_addr_q       <= '0;
      inflight_pc_q   <= 32'd0;
      fifo0_data_q    <= 32'd0;
      fifo0_pc_q      <= 32'd0;
      fifo1_data_q    <= 32'd0;
      fifo1_pc_q      <= 32'd0;
      fifo_cnt_q      <= 2'd0;
      instr_q         <= 32'd0;
      instr_pc_q      <= 32'd0;
      instr_pc_next_q <= 32'd4;
      instr_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      im_read_q       <= im_read_d;
      im_addr_q       <= im_addr_d;
      inflight_pc_q   <= inflight_pc_d;
      fifo0_data_q    <= fifo0_data_d;
      fifo0_pc_q      <= fifo0_pc_d;
      fifo1_data_q    <= fifo1_data_d;
      fifo1_pc_q      <= fifo1_pc_d;
      fifo_cnt_q      <= fifo_cnt_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      instr_pc_next_q <= instr_pc_next_d;
      instr_valid_q   <= instr_valid_d;
    end
  end

  assign im_read       = im_read_q;
  assign im_addr       = im_addr_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_pc_next = instr_pc_next_q;
  assign instr_valid   = instr_valid_q;

  // Decode fields are pure slices of the registered instruction.
  assign opcode        = instr_q[30:25];
  assign sub_op_base   = instr_q[4:0];
  assign sub_op_ls     = instr_q[7:0];
  assign sub_op_j      = instr_q[24];
  assign sub_op_jr     = instr_q[4:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Instruction memory word i holds i, except
// word 0x3F0 which holds 32'h0A1B2C3D for the decode-field check. Inputs are
// driven and outputs sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        im_read;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_next;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  sub_op_base;
  logic [7:0]  sub_op_ls;
  logic        sub_op_j;
  logic [4:0]  sub_op_jr;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .PC_RESET      (32'h0000_0000),
    .IM_ADDR_WIDTH (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .im_read       (im_read),
    .im_addr       (im_addr),
    .im_rdata      (im_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_next (instr_pc_next),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .sub_op_base   (sub_op_base),
    .sub_op_ls     (sub_op_ls),
    .sub_op_j      (sub_op_j),
    .sub_op_jr     (sub_op_jr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: data only while a read is outstanding.
  assign im_rdata = !im_read ? 32'hDEAD_BEEF :
                    (im_addr == 10'h3F0) ? 32'h0A1B2C3D : {22'd0, im_addr};

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    checks++;
    if ({im_read, im_addr, instr, instr_pc, instr_pc_next, instr_valid} !==
        {1'b0, 10'd0, 32'd0, 32'd0, 32'd4, 1'b0}) begin
      errors++;
      $display("FAIL reset_state rd=%b addr=%h instr=%h pc=%h pcn=%h v=%b",
               im_read, im_addr, instr, instr_pc, instr_pc_next, instr_valid);
    end
    checks++;
    if ({opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr} !== 25'd0) begin
      errors++;
      $display("FAIL reset_fields op=%h base=%h ls=%h j=%b jr=%h required 0",
               opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({im_read, im_addr, instr_valid} !== {1'b1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL startup_e0 rd=%b addr=%h v=%b required 1/000/0", im_read, im_addr, instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc, instr_pc_next, im_read, im_addr} !==
          {1'b1, i[31:0], 32'(4 * i), 32'(4 * i + 4), 1'b1, 10'(i + 1)}) begin
        errors++;
        $display("FAIL stream_%0d v=%b instr=%h pc=%h pcn=%h rd=%b addr=%h", i,
                 instr_valid, instr, instr_pc, instr_pc_next, im_read, im_addr);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc, im_read} !== {1'b1, 32'd3, 32'd12, (k == 0)}) begin
        errors++;
        $display("FAIL stall_hold_%0d v=%b instr=%h pc=%h rd=%b required 1/3/c/%b",
                 k, instr_valid, instr, instr_pc, im_read, (k == 0));
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'(4 + k), 32'(16 + 4 * k)}) begin
        errors++;
        $display("FAIL stall_release_%0d v=%b instr=%h pc=%h required %h/%h",
                 k, instr_valid, instr, instr_pc, 4 + k, 16 + 4 * k);
      end
    end
  endtask

  task automatic test_redirect();
    // Word 7 is buffered and word 8 is in flight; both must vanish.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    checks++;
    if ({instr_valid, im_read, im_addr} !== {1'b0, 1'b1, 10'h040}) begin
      errors++;
      $display("FAIL redirect_next v=%b rd=%b addr=%h required 0/1/040", instr_valid, im_read, im_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h40, 32'h100}) begin
      errors++;
      $display("FAIL redirect_target v=%b instr=%h pc=%h required 1/40/100", instr_valid, instr, instr_pc);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h40, 32'h100}) begin
      errors++;
      $display("FAIL redirect_stall_hold v=%b instr=%h pc=%h required 1/40/100", instr_valid, instr, instr_pc);
    end
    stall = 1'b0;
    for (int k = 1; k < 3; k++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'(64 + k), 32'(256 + 4 * k)}) begin
        errors++;
        $display("FAIL redirect_follow_%0d v=%b instr=%h pc=%h", k, instr_valid, instr, instr_pc);
      end
    end
  endtask

  task automatic test_decode();
    redirect = 1'b1; redirect_pc = 32'h0000_0FC0;
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if ({instr, opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr} !==
        {32'h0A1B2C3D, 6'd5, 5'h1D, 8'h3D, 1'b0, 5'h1D}) begin
      errors++;
      $display("FAIL decode_fields instr=%h op=%h base=%h ls=%h j=%b jr=%h",
               instr, opcode, sub_op_base, sub_op_ls, sub_op_j, sub_op_jr);
    end
    checks++;
    if ({instr_pc, instr_pc_next} !== {32'h0FC0, 32'h0FC4}) begin
      errors++;
      $display("FAIL decode_link pc=%h pcn=%h required fc0/fc4", instr_pc, instr_pc_next);
    end
    tick();
    checks++;
    if ({instr, opcode, sub_op_base, sub_op_ls} !== {32'h3F1, 6'd0, 5'h11, 8'hF1}) begin
      errors++;
      $display("FAIL decode_next instr=%h op=%h base=%h ls=%h", instr, opcode, sub_op_base, sub_op_ls);
    end
  endtask

  task automatic test_reset_mid();
    // Reset wins over a simultaneous redirect; in-flight word 0x3F2 is lost.
    reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    checks++;
    if ({im_read, im_addr, instr, instr_pc, instr_pc_next, instr_valid, opcode} !==
        {1'b0, 10'd0, 32'd0, 32'd0, 32'd4, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL midreset_state rd=%b addr=%h instr=%h pc=%h pcn=%h v=%b",
               im_read, im_addr, instr, instr_pc, instr_pc_next, instr_valid);
    end
    reset = 1'b1; redirect = 1'b0;
    tick();
    checks++;
    if ({im_read, im_addr, instr_valid} !== {1'b1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_refetch rd=%b addr=%h v=%b required 1/000/0", im_read, im_addr, instr_valid);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL midreset_first v=%b instr=%h pc=%h required 1/0/0", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    checks++;
    if ({instr_valid, im_addr} !== {1'b0, 10'h0C0}) begin
      errors++;
      $display("FAIL b2b_redirect v=%b addr=%h required 0/0c0", instr_valid, im_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hC0, 32'h300}) begin
      errors++;
      $display("FAIL b2b_target v=%b instr=%h pc=%h required 1/c0/300", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    checks++;
    if (im_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_addr addr=%h required 3ff", im_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc, instr_pc_next} !== {1'b1, 32'h3FF, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_top instr=%h pc=%h pcn=%h", instr, instr_pc, instr_pc_next);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'(k), 32'(4 * k)}) begin
        errors++;
        $display("FAIL wrap_seq_%0d instr=%h pc=%h", k, instr, instr_pc);
      end
    end
  endtask

  task automatic test_unaligned();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    checks++;
    if (im_addr !== 10'h040) begin
      errors++;
      $display("FAIL unaligned_addr addr=%h required 040", im_addr);
    end
    tick();
    checks++;
    if ({instr, instr_pc} !== {32'h40, 32'h102}) begin
      errors++;
      $display("FAIL unaligned_first instr=%h pc=%h required 40/102", instr, instr_pc);
    end
    tick();
    checks++;
    if ({instr, instr_pc} !== {32'h41, 32'h106}) begin
      errors++;
      $display("FAIL unaligned_second instr=%h pc=%h required 41/106", instr, instr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_decode();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    test_unaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
